// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 max-pool with optional ReLU on a raster-order sample stream.
// One half-row line buffer holds the horizontal maxima of each even row until the odd row pairs with them.
module maxpool2x2_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int IN_W       = 4,
  parameter int IN_H       = 4,
  parameter bit RELU       = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  frame_done_o
);
  localparam int CW       = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int RW       = (IN_H > 1) ? $clog2(IN_H) : 1;
  localparam int LB_DEPTH = IN_W / 2;
  localparam int LBW      = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam bit ODD_W    = (IN_W % 2) != 0;

  logic [CW-1:0]                col_q, col_d, col_half;
  logic [RW-1:0]                row_q, row_d;
  logic signed [DATA_WIDTH-1:0] h_q, x, hmax, vmax, lb_rd;
  logic signed [DATA_WIDTH-1:0] lbuf [LB_DEPTH];
  logic [LBW-1:0]               lidx;
  logic                         last_col, last_row, skip_col;
  logic                         valid_q, done_q;
  logic [DATA_WIDTH-1:0]        data_q;

  assign last_col = (col_q == CW'(IN_W - 1));
  assign last_row = (row_q == RW'(IN_H - 1));
  // With an odd width the trailing column has no partner and must not disturb h_q.
  assign skip_col = ODD_W && last_col;
  assign col_half = col_q >> 1;
  assign lidx     = col_half[LBW-1:0];
  assign lb_rd    = lbuf[lidx];

  always_comb begin
    x = $signed(data_i);
    if (RELU && x < 0) x = '0;
    hmax = (x > h_q) ? x : h_q;
    vmax = (lb_rd > hmax) ? lb_rd : hmax;
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (valid_i) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      h_q     <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      if (valid_i) begin
        if (!col_q[0] && !skip_col) h_q <= x;
        if (col_q[0] && row_q[0]) begin
          data_q  <= vmax;
          valid_q <= 1'b1;
        end
        done_q <= last_col && last_row;
      end
    end
  end

  // Every entry is written on an even row before the odd row reads it, so no reset is needed.
  always_ff @(posedge clk) begin
    if (valid_i && col_q[0] && !row_q[0]) lbuf[lidx] <= hmax;
  end

  assign valid_o      = valid_q;
  assign data_o       = data_q;
  assign frame_done_o = done_q;
endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Directed bench: 4x4 instances with and without ReLU share one stream; a 3x3 instance covers odd dimensions.
module tb_maxpool2x2_stream;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, valid2;
  logic [15:0] data_i, data2;
  logic        v0, v1, v2, fd0, fd1, fd2;
  logic [15:0] d0, d1, d2;
  int          total = 0;
  int          fails = 0;
  logic [15:0] px [16];
  logic [15:0] exp0 [4];
  logic [15:0] exp1 [4];

  always #5 clk = ~clk;

  maxpool2x2_stream #(.DATA_WIDTH(16), .IN_W(4), .IN_H(4), .RELU(1'b0)) u0 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .data_i(data_i),
    .valid_o(v0), .data_o(d0), .frame_done_o(fd0));
  maxpool2x2_stream #(.DATA_WIDTH(16), .IN_W(4), .IN_H(4), .RELU(1'b1)) u1 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .data_i(data_i),
    .valid_o(v1), .data_o(d1), .frame_done_o(fd1));
  maxpool2x2_stream #(.DATA_WIDTH(16), .IN_W(3), .IN_H(3), .RELU(1'b0)) u2 (
    .clk(clk), .rst(rst), .valid_i(valid2), .data_i(data2),
    .valid_o(v2), .data_o(d2), .frame_done_o(fd2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive px[] as one 4x4 frame with 'gap' idle cycles after each pixel; check both 4x4 instances.
  task automatic frame(input string tag, input int gap);
    int k = 0;
    for (int i = 0; i < 16; i++) begin
      valid_i = 1'b1;
      data_i  = px[i];
      @(negedge clk);
      valid_i = 1'b0;
      if (i == 5 || i == 7 || i == 13 || i == 15) begin
        chk({tag, ".v0"}, 32'(v0), 32'd1);
        chk({tag, ".d0"}, 32'(d0), 32'(exp0[k]));
        chk({tag, ".v1"}, 32'(v1), 32'd1);
        chk({tag, ".d1"}, 32'(d1), 32'(exp1[k]));
        k++;
      end else begin
        chk({tag, ".idle_v0"}, 32'(v0), 32'd0);
        chk({tag, ".idle_v1"}, 32'(v1), 32'd0);
      end
      chk({tag, ".fd0"}, 32'(fd0), (i == 15) ? 32'd1 : 32'd0);
      chk({tag, ".fd1"}, 32'(fd1), (i == 15) ? 32'd1 : 32'd0);
      repeat (gap) begin
        @(negedge clk);
        chk({tag, ".gap_v0"}, 32'(v0), 32'd0);
        chk({tag, ".gap_fd0"}, 32'(fd0), 32'd0);
      end
    end
  endtask

  task automatic set_ramp(input bit down);
    for (int i = 0; i < 16; i++) px[i] = down ? 16'(15 - i) : 16'(i);
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; data_i = '0; valid2 = 1'b0; data2 = '0;
    repeat (2) @(negedge clk);
    chk("rst.v0", 32'(v0), 32'd0);
    chk("rst.d0", 32'(d0), 32'd0);
    chk("rst.fd0", 32'(fd0), 32'd0);
    chk("rst.v2", 32'(v2), 32'd0);
    rst = 1'b0;

    // Ramp 0..15: both ReLU settings agree on non-negative data.
    set_ramp(1'b0);
    exp0 = '{16'd5, 16'd7, 16'd13, 16'd15};
    exp1 = '{16'd5, 16'd7, 16'd13, 16'd15};
    frame("ramp", 0);

    // All -3: ReLU clamps to zero, bypass keeps the negative value.
    for (int i = 0; i < 16; i++) px[i] = 16'hFFFD;
    exp0 = '{16'hFFFD, 16'hFFFD, 16'hFFFD, 16'hFFFD};
    exp1 = '{16'h0, 16'h0, 16'h0, 16'h0};
    frame("neg3", 0);

    // Sparse valid: one sample every third cycle.
    set_ramp(1'b0);
    exp0 = '{16'd5, 16'd7, 16'd13, 16'd15};
    exp1 = exp0;
    frame("gap", 2);

    // Back-to-back frames, up then down.
    frame("b2b_up", 0);
    set_ramp(1'b1);
    exp0 = '{16'd15, 16'd13, 16'd7, 16'd5};
    exp1 = exp0;
    frame("b2b_dn", 0);

    // Signed extremes: 7FFF must beat 8000 in both modes.
    for (int i = 0; i < 16; i++) px[i] = 16'h8000;
    px[0] = 16'h7FFF;
    exp0 = '{16'h7FFF, 16'h8000, 16'h8000, 16'h8000};
    exp1 = '{16'h7FFF, 16'h0, 16'h0, 16'h0};
    frame("signed", 0);

    // Reset after 6 pixels, then a clean frame.
    set_ramp(1'b0);
    for (int i = 0; i < 6; i++) begin
      valid_i = 1'b1; data_i = px[i];
      @(negedge clk);
    end
    valid_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.v0", 32'(v0), 32'd0);
    chk("midrst.d0", 32'(d0), 32'd0);
    chk("midrst.d1", 32'(d1), 32'd0);
    exp0 = '{16'd5, 16'd7, 16'd13, 16'd15};
    exp1 = exp0;
    frame("after_rst", 0);

    // 3x3: one window from the top-left 2x2, last column and row ignored, done after the last pixel.
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 9; i++) begin
        valid2 = 1'b1;
        data2  = (f == 0) ? 16'(i) : 16'(8 - i);
        @(negedge clk);
        valid2 = 1'b0;
        chk("odd.v2", 32'(v2), (i == 4) ? 32'd1 : 32'd0);
        if (i == 4) chk("odd.d2", 32'(d2), (f == 0) ? 32'd4 : 32'd8);
        chk("odd.fd2", 32'(fd2), (i == 8) ? 32'd1 : 32'd0);
      end
    end
    chk("odd.hold_d2", 32'(d2), 32'd8);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
